// File: rtl/delay_ctrl.sv
// Sequencer for the delay/echo datapath: decodes effect switches into a delay mode,
// drives BRAM pointers, feedback shift and write-source select, and zero-fills the
// delay memory on every mode change. Mode change takes effect 3 clocks after the switches move.
module delay_ctrl #(
    parameter int T         = 20000,
    parameter int B         = 15,
    parameter int SWEEP_MIN = 16,
    parameter int SWEEP_MAX = 2440
) (
    input  logic         clk_48,
    input  logic         rst,
    input  logic [3:0]   options,
    input  logic [3:0]   en,
    input  logic         sample_tick,
    output logic         we,
    output logic [B-1:0] waddr,
    output logic [B-1:0] raddr,
    output logic         wsel,
    output logic [1:0]   fb_shift,
    output logic         active,
    output logic         mute,
    output logic         busy,
    output logic [B-1:0] delay_len
);

    // One extra bit so lengths up to T and the "+1" pointer compare never overflow.
    localparam int LW = B + 1;
    localparam logic [LW-1:0] LEN_FULL  = LW'(T);
    localparam logic [LW-1:0] LEN_HALF  = LW'(T / 2);
    localparam logic [LW-1:0] LAST_ADDR = LW'(T - 1);
    localparam logic [LW-1:0] SMIN      = LW'(SWEEP_MIN);
    localparam logic [LW-1:0] SMAX      = LW'(SWEEP_MAX);

    typedef enum logic [2:0] {
        M_BYPASS, M_LONG, M_SHORT, M_AMB, M_SWEEP_IIR, M_SWEEP_FIR
    } mode_t;

    typedef enum logic [1:0] {S_BYPASS, S_CLEAR, S_RUN} state_t;

    logic [3:0]    opt_s1, opt_s2;
    logic          en_s1, en_s2;
    mode_t         mode, cur_mode, cur_nx;
    state_t        state, state_nx;
    logic [B-1:0]  waddr_nx;
    logic [LW-1:0] sweep, sweep_nx, cur_len;
    logic          dir_down, dir_nx;
    logic          chg;
    logic          unused_en_bits;

    // Only en[3] gates the effect; the rest of the bank is wired elsewhere.
    assign unused_en_bits = ^en[2:0];

    function automatic logic [1:0] fb_of(input mode_t m);
        case (m)
            M_AMB:                                         fb_of = 2'd3;
            M_LONG, M_SHORT, M_SWEEP_IIR, M_SWEEP_FIR:     fb_of = 2'd1;
            default:                                       fb_of = 2'd0;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            opt_s1 <= '0;
            opt_s2 <= '0;
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
        end else begin
            opt_s1 <= options;
            opt_s2 <= opt_s1;
            en_s1  <= en[3];
            en_s2  <= en_s1;
        end
    end

    // Decode synchronised switches into the requested mode.
    always_comb begin
        mode = M_BYPASS;
        if (en_s2) begin
            case (opt_s2)
                4'b1000: mode = M_LONG;
                4'b1100: mode = M_SHORT;
                4'b1110: mode = M_AMB;
                4'b0100: mode = M_SWEEP_IIR;
                4'b0010: mode = M_SWEEP_FIR;
                default: mode = M_BYPASS;
            endcase
        end
    end

    // Delay length of the committed mode; sweep modes follow the triangle.
    always_comb begin
        case (cur_mode)
            M_LONG:                   cur_len = LEN_FULL;
            M_SHORT, M_AMB:           cur_len = LEN_HALF;
            M_SWEEP_IIR, M_SWEEP_FIR: cur_len = sweep;
            default:                  cur_len = '0;
        endcase
    end

    assign chg = (mode != cur_mode);

    // Next-state for the FSM, pointers and sweep; a mode change overrides any tick.
    always_comb begin
        state_nx = state;
        cur_nx   = cur_mode;
        waddr_nx = waddr;
        sweep_nx = sweep;
        dir_nx   = dir_down;
        if (chg) begin
            state_nx = S_CLEAR;
            cur_nx   = mode;
            waddr_nx = '0;
            sweep_nx = SMIN;
            dir_nx   = 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if ({1'b0, waddr} == LAST_ADDR) begin
                        waddr_nx = '0;
                        state_nx = (cur_mode == M_BYPASS) ? S_BYPASS : S_RUN;
                    end else begin
                        waddr_nx = waddr + 1'b1;
                    end
                end
                S_RUN: begin
                    if (sample_tick) begin
                        // >= rather than == so a shrinking sweep can never strand the pointer.
                        waddr_nx = ({1'b0, waddr} >= cur_len - 1'b1) ? '0 : waddr + 1'b1;
                        if (cur_mode == M_SWEEP_IIR || cur_mode == M_SWEEP_FIR) begin
                            if (!dir_down) begin
                                sweep_nx = sweep + 1'b1;
                                if (sweep_nx == SMAX) dir_nx = 1'b1;
                            end else begin
                                sweep_nx = sweep - 1'b1;
                                if (sweep_nx == SMIN) dir_nx = 1'b0;
                            end
                        end
                    end
                end
                default: waddr_nx = '0;
            endcase
        end
    end

    // FSM state, pointers and registered control outputs.
    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            state    <= S_BYPASS;
            cur_mode <= M_BYPASS;
            waddr    <= '0;
            sweep    <= SMIN;
            dir_down <= 1'b0;
            busy     <= 1'b0;
            mute     <= 1'b0;
            active   <= 1'b0;
            fb_shift <= 2'd0;
            wsel     <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_mode <= cur_nx;
            waddr    <= waddr_nx;
            sweep    <= sweep_nx;
            dir_down <= dir_nx;
            busy     <= (state_nx == S_CLEAR);
            mute     <= (state_nx == S_CLEAR);
            active   <= (state_nx == S_RUN);
            fb_shift <= (state_nx == S_RUN) ? fb_of(cur_nx) : 2'd0;
            wsel     <= (state_nx == S_RUN) && (cur_nx == M_SWEEP_FIR);
        end
    end

    // Writes: every clock while clearing, once per sample while running.
    assign we        = busy | (active & sample_tick & ~chg);
    // Read the oldest sample: one slot ahead of the write pointer, wrapping at len.
    assign raddr     = !active ? '0 :
                       (({1'b0, waddr} + 1'b1) >= cur_len) ? '0 : waddr + 1'b1;
    assign delay_len = cur_len[B-1:0];

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl with a small memory (T=16) and sweep 4..8.
// Expected observations are queued with their stimulus and compared cycle by cycle.
module tb_delay_ctrl;

    logic       clk_48 = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] options = 4'b0000;
    logic [3:0] en = 4'b0000;
    logic       sample_tick = 1'b0;
    logic       we, wsel, active, mute, busy;
    logic [4:0] waddr, raddr, delay_len;
    logic [1:0] fb_shift;

    delay_ctrl #(.T(16), .B(5), .SWEEP_MIN(4), .SWEEP_MAX(8)) dut (
        .clk_48(clk_48), .rst(rst), .options(options), .en(en),
        .sample_tick(sample_tick), .we(we), .waddr(waddr), .raddr(raddr),
        .wsel(wsel), .fb_shift(fb_shift), .active(active), .mute(mute),
        .busy(busy), .delay_len(delay_len)
    );

    always #5 clk_48 = ~clk_48;

    typedef struct packed {
        logic       busy, mute, we, active, wsel;
        logic [1:0] fb;
        logic [4:0] waddr, raddr, len;
    } exp_t;

    typedef struct packed {
        logic       tick;
        logic [3:0] opt;
        logic [3:0] en_v;
        exp_t       exp;
    } ent_t;

    ent_t       sbq[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] o_cur = 4'b0000;
    logic [3:0] e_cur = 4'b0000;
    exp_t       last = '0;
    int         rw = 0;
    // Delay length seen after each successive tick in a sweep mode.
    int         sweep_tbl[14] = '{4, 5, 6, 7, 8, 7, 6, 5, 4, 5, 6, 7, 8, 7};

    function automatic exp_t mk(input logic b, input logic w_e, input logic act, input logic ws,
                                input int fb, input int wa, input int ra, input int ln);
        exp_t x;
        x.busy = b; x.mute = b; x.we = w_e; x.active = act; x.wsel = ws;
        x.fb = 2'(fb); x.waddr = 5'(wa); x.raddr = 5'(ra); x.len = 5'(ln);
        return x;
    endfunction

    function automatic exp_t obs();
        return {busy, mute, we, active, wsel, fb_shift, waddr, raddr, delay_len};
    endfunction

    function automatic int rnext(input int w, input int ln);
        return (w + 1 >= ln) ? 0 : w + 1;
    endfunction

    task automatic push(input logic tk, input exp_t x);
        sbq.push_back('{tk, o_cur, e_cur, x});
        last = x;
    endtask

    // Switches move now; old state holds (tick low) for the 3 synchroniser/detect cycles.
    task automatic push_sync();
        exp_t x = last;
        for (int i = 0; i < 3; i++) push(1'b0, x);
    endtask

    task automatic push_clear(input int lo, input int hi, input int ln);
        for (int i = lo; i <= hi; i++) push(1'b1, mk(1, 1, 0, 0, 0, i, 0, ln));
        rw = 0;
    endtask

    task automatic push_bypass(input int n);
        for (int i = 0; i < n; i++) push(1'b1, '0);
    endtask

    task automatic push_run(input int n, input int ln, input int fb, input int p);
        logic tk;
        for (int i = 0; i < n; i++) begin
            tk = ((i % p) == 0);
            push(tk, mk(0, tk, 1, 0, fb, rw, rnext(rw, ln), ln));
            if (tk) rw = (rw >= ln - 1) ? 0 : rw + 1;
        end
        push(1'b0, mk(0, 0, 1, 0, fb, rw, rnext(rw, ln), ln));
    endtask

    task automatic push_sweep(input int n);
        logic tk;
        int   k = 0;
        for (int i = 0; i < n; i++) begin
            tk = ((i % 3) != 2);
            push(tk, mk(0, tk, 1, 1, 1, rw, rnext(rw, sweep_tbl[k]), sweep_tbl[k]));
            if (tk) begin
                rw = (rw >= sweep_tbl[k] - 1) ? 0 : rw + 1;
                k++;
            end
        end
        push(1'b0, mk(0, 0, 1, 1, 1, rw, rnext(rw, sweep_tbl[k]), sweep_tbl[k]));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== exp_t'(0)) begin
            n_err++;
            $display("FAIL reset_async: got %h expected %h", obs(), exp_t'(0));
        end
        repeat (3) @(posedge clk_48);
        #1;
        n_cmp++;
        if (obs() !== exp_t'(0)) begin
            n_err++;
            $display("FAIL reset_held: got %h expected %h", obs(), exp_t'(0));
        end
    endtask

    task automatic test_long();
        ent_t e;
        int   idx = 0;
        rst = 1'b0;
        o_cur = 4'b1000; e_cur = 4'b1000; last = '0;
        push_sync();
        push_clear(0, 15, 16);
        push_run(20, 16, 1, 1);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk_48); #1;
            sample_tick = e.tick; options = e.opt; en = e.en_v;
            #1;
            n_cmp++;
            if (obs() !== e.exp) begin
                n_err++;
                $display("FAIL long[%0d]: got %h expected %h", idx, obs(), e.exp);
            end
            idx++;
        end
    endtask

    task automatic test_amb_sparse();
        ent_t e;
        int   idx = 0;
        o_cur = 4'b1110;
        push_sync();
        push_clear(0, 15, 8);
        push_run(40, 8, 3, 4);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk_48); #1;
            sample_tick = e.tick; options = e.opt; en = e.en_v;
            #1;
            n_cmp++;
            if (obs() !== e.exp) begin
                n_err++;
                $display("FAIL amb[%0d]: got %h expected %h", idx, obs(), e.exp);
            end
            idx++;
        end
    endtask

    task automatic test_sweep_fir();
        ent_t e;
        int   idx = 0;
        o_cur = 4'b0010;
        push_sync();
        push_clear(0, 15, 4);
        push_sweep(18);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk_48); #1;
            sample_tick = e.tick; options = e.opt; en = e.en_v;
            #1;
            n_cmp++;
            if (obs() !== e.exp) begin
                n_err++;
                $display("FAIL sweep[%0d]: got %h expected %h", idx, obs(), e.exp);
            end
            if (active === 1'b1) begin
                n_cmp++;
                if (raddr >= delay_len) begin
                    n_err++;
                    $display("FAIL sweep_raddr[%0d]: raddr %0d not below delay_len %0d",
                             idx, raddr, delay_len);
                end
            end
            idx++;
        end
    endtask

    task automatic test_mid_clear();
        ent_t e;
        int   idx = 0;
        o_cur = 4'b1000;
        push_sync();
        for (int i = 0; i <= 9; i++) begin
            if (i == 7) o_cur = 4'b1100;
            push(1'b1, mk(1, 1, 0, 0, 0, i, 0, 16));
        end
        push_clear(0, 15, 8);
        push_run(6, 8, 1, 1);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk_48); #1;
            sample_tick = e.tick; options = e.opt; en = e.en_v;
            #1;
            n_cmp++;
            if (obs() !== e.exp) begin
                n_err++;
                $display("FAIL mid_clear[%0d]: got %h expected %h", idx, obs(), e.exp);
            end
            idx++;
        end
    endtask

    task automatic test_disable();
        ent_t e;
        int   idx = 0;
        e_cur = 4'b0000;
        push_sync();
        push_clear(0, 15, 0);
        push_bypass(4);
        o_cur = 4'b1000; e_cur = 4'b1000;
        push_sync();
        push_clear(0, 15, 16);
        push_run(4, 16, 1, 1);
        o_cur = 4'b0110;
        push_sync();
        push_clear(0, 15, 0);
        push_bypass(4);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk_48); #1;
            sample_tick = e.tick; options = e.opt; en = e.en_v;
            #1;
            n_cmp++;
            if (obs() !== e.exp) begin
                n_err++;
                $display("FAIL disable[%0d]: got %h expected %h", idx, obs(), e.exp);
            end
            idx++;
        end
    endtask

    task automatic test_async_reset();
        ent_t e;
        int   idx = 0;
        o_cur = 4'b1000;
        push_sync();
        push_clear(0, 15, 16);
        push_run(5, 16, 1, 1);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk_48); #1;
            sample_tick = e.tick; options = e.opt; en = e.en_v;
            #1;
            n_cmp++;
            if (obs() !== e.exp) begin
                n_err++;
                $display("FAIL async_pre[%0d]: got %h expected %h", idx, obs(), e.exp);
            end
            idx++;
        end
        // Mid-cycle reset pulse, well away from either clock edge.
        sample_tick = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== exp_t'(0)) begin
            n_err++;
            $display("FAIL async_rst: got %h expected %h", obs(), exp_t'(0));
        end
        #1 rst = 1'b0;
        // Switches already at LONG: only the 2 synchroniser cycles precede CLEAR.
        push_bypass(2);
        push_clear(0, 15, 16);
        push_run(3, 16, 1, 1);
        idx = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk_48); #1;
            sample_tick = e.tick; options = e.opt; en = e.en_v;
            #1;
            n_cmp++;
            if (obs() !== e.exp) begin
                n_err++;
                $display("FAIL async_post[%0d]: got %h expected %h", idx, obs(), e.exp);
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_long();
        test_amb_sparse();
        test_sweep_fir();
        test_mid_clear();
        test_disable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
